rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the integer register file. It shares the register file's single write port between two producers, the ALU and the load/store unit, using a valid/ready handshake. Grants are fixed-priority with an anti-starvation counter. It also keeps one busy bit per architectural register so that issue stalls on RAW/WAW hazards. It sits between the execute/memory stages and the register file, and drives the register file's write port from registered outputs.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_scoreboard.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and sizes for the integer register file write-back path.
package rf_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREG      = 32;

  // Source of the write registered onto the register file port.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LSU
  } wb_src_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, issue stall on RAW/WAW.
module rf_scoreboard #(
  parameter int unsigned NREG = rf_pkg::NREG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_en,
  input  logic [rf_pkg::REG_IDX_W-1:0] clr_idx,
  input  logic                         iss_valid,
  input  logic [rf_pkg::REG_IDX_W-1:0] iss_rd,
  input  logic [rf_pkg::REG_IDX_W-1:0] iss_rs1,
  input  logic [rf_pkg::REG_IDX_W-1:0] iss_rs2,
  output logic                         iss_stall
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            set_en;

  // Stall on any operand or destination still owned by an in-flight producer.
  always_comb begin
    iss_stall = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd]);
    set_en    = iss_valid & ~iss_stall & (iss_rd != '0);
  end

  // Clear first, then set, so a newly issued producer outranks a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: fixed priority LSU over ALU with an ALU anti-starvation
// counter, registered register-file write port, and the issue scoreboard.
module rf_wb_arbiter #(
  parameter int unsigned XLEN    = rf_pkg::XLEN,
  parameter int unsigned NREG    = rf_pkg::NREG,
  parameter int unsigned AGE_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [rf_pkg::REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [rf_pkg::REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]              lsu_data,
  input  logic                         iss_valid,
  input  logic [rf_pkg::REG_IDX_W-1:0] iss_rd,
  input  logic [rf_pkg::REG_IDX_W-1:0] iss_rs1,
  input  logic [rf_pkg::REG_IDX_W-1:0] iss_rs2,
  output logic                         iss_stall,
  output logic                         rf_we,
  output logic [rf_pkg::REG_IDX_W-1:0] rf_rd,
  output logic [XLEN-1:0]              rf_wdata
);

  import rf_pkg::*;

  localparam int unsigned        StarveW   = $clog2(AGE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(AGE_MAX);

  logic                 grant_alu, grant_lsu, handshake;
  logic [REG_IDX_W-1:0] win_rd;
  logic [XLEN-1:0]      win_data;

  logic [StarveW-1:0]   starve_q, starve_d;
  wb_src_t              wb_src_q, wb_src_d;
  logic [REG_IDX_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;

  // Grant: LSU first unless the ALU has lost AGE_MAX times in a row.
  always_comb begin
    grant_lsu = lsu_valid & ~(alu_valid & (starve_q == StarveMax));
    grant_alu = alu_valid & ~grant_lsu;
    handshake = grant_alu | grant_lsu;
    win_rd    = grant_lsu ? lsu_rd : alu_rd;
    win_data  = grant_lsu ? lsu_data : alu_data;
  end

  // Count consecutive ALU losses, saturating at AGE_MAX.
  always_comb begin
    starve_d = starve_q;
    if (!alu_valid || grant_alu)   starve_d = '0;
    else if (starve_q != StarveMax) starve_d = starve_q + 1'b1;
  end

  // Next write-port contents; index/data hold when nothing is granted.
  always_comb begin
    wb_src_d   = WB_NONE;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (handshake) begin
      rf_rd_d    = win_rd;
      rf_wdata_d = win_data;
      if (win_rd != '0) wb_src_d = grant_lsu ? WB_LSU : WB_ALU;
    end
  end

  // State registers; reset discards any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q   <= '0;
      wb_src_q   <= WB_NONE;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      wb_src_q   <= wb_src_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;
  assign rf_we     = (wb_src_q != WB_NONE);
  assign rf_rd     = rf_rd_q;
  assign rf_wdata  = rf_wdata_q;

  rf_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .clr_en    (handshake),
    .clr_idx   (win_rd),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall)
  );

endmodule
